ms_jk_flipflop: RTL and testbench
=================================

// Module: ms_jk_flipflop
// PURPOSE
//  Master-slave JK flip-flop bank: WIDTH independent JK bits, each a master stage plus a slave stage.
//  Master captures the JK command on the rising clk edge; slave transfers master to q on the falling edge.
//  Output therefore changes only on the falling edge, which removes JK race-around.
//  Used as a generic storage/toggle primitive in control paths and divider chains.
// PARAMETERS
//  WIDTH  1  number of independent JK bits (>=1); all ports below are WIDTH wide except clk/rst
// PORTS
//  clk   in   1      single clock; master samples on posedge, slave updates on negedge
//  rst   in   1      synchronous, active-high reset, sampled on posedge clk
//  j     in   WIDTH  per-bit J (set) input
//  k     in   WIDTH  per-bit K (reset) input
//  q     out  WIDTH  slave-stage output
//  qbar  out  WIDTH  always exactly ~q (combinational, no extra state)
// BEHAVIOUR
//  - State per bit: m (master), s (slave). q = s, qbar = ~s.
//  - Posedge clk, rst=1: m<=0 and s<=0 on the same edge, so q=0, qbar=1 immediately after that posedge.
//  - Posedge clk, rst=0: m <= {j,k}: 00 hold s, 01 -> 0, 10 -> 1, 11 -> ~s.
//    The toggle and hold cases use the current slave value, never m.
//  - Negedge clk: s <= m. Reset has no effect at negedge; an already-cleared m propagates 0.
//  - Latency: j/k sampled at posedge N appear on q at the following negedge (half a clock period).
//  - j/k changes between posedges have no effect: no transparency and no race-around.
//    Exactly one toggle per clock period with j=k=1.
//  - Reset mid-operation: a pending master value is discarded and q goes to 0 at the reset posedge.
//    Normal operation resumes at the first posedge with rst=0.
//  - Power-up before the first reset: q undefined (X in simulation); the bench must apply rst first.
//  - All bits are fully independent; no cross-bit interaction.
// CONFIGURATION
//  Macro MS_JK_CLKEN_EN.
//  - Defined: adds port ce (in, 1) after rst.
//    Posedge with rst=0 and ce=0: m <= s (hold), so q is unchanged at the next negedge.
//    rst overrides ce.
//  - Undefined: no ce port; behaviour identical to ce tied to 1.
// STRUCTURE
//  - Package ms_jk_pkg: typedef enum logic [1:0] jk_cmd_t {JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11};
//    Also holds function jk_next(cmd, cur) returning the next master value.
//  - Sub-module ms_jk_bit: one master/slave bit pair (clk, rst, [ce], j, k, q).
//    Top generates WIDTH instances and ties qbar = ~q.
// TESTING
//  (clk period 20 ns, posedges at 10, 30, 50, ...; WIDTH=1 unless stated)
//  1 Reset: rst=1 for one posedge, j=k=1 -> q=0, qbar=1 after that posedge.
//    q stays 0 through the following negedge.
//  2 Set/reset: rst=0. j=1,k=0 at posedge -> q=1 at next negedge.
//    Then j=0,k=1 -> q=0 one negedge later. j=0,k=0 -> q holds across 3 cycles.
//  3 Toggle: j=k=1 for 4 cycles from q=0 -> q = 1,0,1,0 on successive negedges.
//    Exactly one change per period, never on a posedge.
//  4 Mid-cycle glitch: from q=0, pulse j=1 only between a negedge and the next posedge, low at the posedge -> q stays 0.
//  5 Reset during toggle: j=k=1 running, assert rst at one posedge -> q=0 at that posedge.
//    Deassert rst -> toggling resumes; first change is q=1 at the next negedge.
//  6 MS_JK_CLKEN_EN with WIDTH=4: ce=0 and j=4'hF,k=0 -> q unchanged.
//    ce=1 -> q=4'hF at next negedge. With j=4'hA,k=4'h5 -> q=4'hA. qbar==~q on every sample.

Source files
------------

// File: rtl/ms_jk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ms_jk_pkg
// Description : JK command encoding and next-state helper for ms_jk_flipflop.
// Revision    : 1.0 - initial release
// ============================================================================
package ms_jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_t;

  // Next master value; cur is always the slave (visible) value.
  function automatic logic jk_next(input jk_cmd_t cmd, input logic cur);
    logic nxt;
    nxt = cur;
    case (cmd)
      JK_HOLD:   nxt = cur;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~cur;
      default:   nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ms_jk_bit.sv
`default_nettype none
// ============================================================================
// Module      : ms_jk_bit
// Description : One master/slave JK bit. Master on posedge, slave on negedge.
//               Optional clock enable when MS_JK_CLKEN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ms_jk_bit
  import ms_jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
`ifdef MS_JK_CLKEN_EN
  input  logic ce,
`endif
  input  logic j,
  input  logic k,
  output logic q
);

  logic    m_d, m_q;
  logic    s_d, s_q;
  logic    rst_d, rst_q;
  logic    w_en;
  jk_cmd_t w_cmd;

`ifdef MS_JK_CLKEN_EN
  assign w_en = ce;
`else
  assign w_en = 1'b1;
`endif

  // The slave only clocks on negedge, so a reset seen at the posedge masks
  // it until the cleared master has propagated half a period later.
  assign q = rst_q ? 1'b0 : s_q;

  always_comb begin
    w_cmd = jk_cmd_t'({j, k});
    rst_d = rst;
    s_d   = m_q;
    m_d   = q;
    if (rst) begin
      m_d = 1'b0;
    end else if (w_en) begin
      m_d = jk_next(w_cmd, q);
    end
  end

  always_ff @(posedge clk) begin
    m_q   <= m_d;
    rst_q <= rst_d;
  end

  always_ff @(negedge clk) begin
    s_q <= s_d;
  end

endmodule
`default_nettype wire

// File: rtl/ms_jk_flipflop.sv
`default_nettype none
// ============================================================================
// Module      : ms_jk_flipflop
// Description : Bank of WIDTH independent master-slave JK flip-flops.
//               Define MS_JK_CLKEN_EN to add a shared clock-enable port ce.
// Revision    : 1.0 - initial release
// ============================================================================
module ms_jk_flipflop #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MS_JK_CLKEN_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      ms_jk_bit u_bit (
        .clk (clk),
        .rst (rst),
`ifdef MS_JK_CLKEN_EN
        .ce  (ce),
`endif
        .j   (j[gi]),
        .k   (k[gi]),
        .q   (q[gi])
      );
    end
  endgenerate

  assign qbar = ~q;

endmodule
`default_nettype wire

// File: tb/tb_ms_jk_flipflop.sv
`default_nettype none
// ============================================================================
// Module      : tb_ms_jk_flipflop
// Description : Directed self-checking bench for ms_jk_flipflop (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ms_jk_flipflop;

  localparam int C_W = 4;

  logic           clk;
  logic           rst;
  logic           ce;
  logic [C_W-1:0] j;
  logic [C_W-1:0] k;
  logic [C_W-1:0] q;
  logic [C_W-1:0] qbar;

  int n_total;
  int n_bad;

  ms_jk_flipflop #(.WIDTH(C_W)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef MS_JK_CLKEN_EN
    .ce   (ce),
`endif
    .j    (j),
    .k    (k),
    .q    (q),
    .qbar (qbar)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [C_W-1:0] got, input logic [C_W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one command, then check q/qbar just after the posedge and the negedge.
  task automatic cyc(input string tag, input logic rv, input logic cv,
                     input logic [C_W-1:0] jv, input logic [C_W-1:0] kv,
                     input logic [C_W-1:0] exp_pos, input logic [C_W-1:0] exp_neg);
    rst = rv;
    ce  = cv;
    j   = jv;
    k   = kv;
    @(posedge clk);
    #1;
    chk({tag, "_pos_q"},    q,    exp_pos);
    chk({tag, "_pos_qbar"}, qbar, ~exp_pos);
    @(negedge clk);
    #1;
    chk({tag, "_neg_q"},    q,    exp_neg);
    chk({tag, "_neg_qbar"}, qbar, ~exp_neg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1; ce = 1'b1; j = '1; k = '1;

    // Reset with j=k=1 pending
    cyc("reset", 1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0);

    // Set / reset / hold
    cyc("set",   1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'hF);
    cyc("clr",   1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 4'h0);
    cyc("set2",  1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'hF);
    for (int i = 0; i < 3; i++) cyc("hold", 1'b0, 1'b1, 4'h0, 4'h0, 4'hF, 4'hF);
    cyc("clr2",  1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 4'h0);

    // Toggle: one change per period, only on negedge
    cyc("tog1", 1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF);
    cyc("tog2", 1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0);
    cyc("tog3", 1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF);
    cyc("tog4", 1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0);

    // J pulse between negedge and posedge, low at the posedge
    j = 4'hF; k = 4'h0;
    #5;
    j = 4'h0;
    cyc("glitch", 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);

    // Reset in the middle of toggling
    cyc("rtog1", 1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF);
    cyc("rtog_rst", 1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0);
    cyc("rtog_resume", 1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF);
    cyc("rtog2", 1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0);

    // Per-bit independence from q=F: toggle, set, reset, hold -> 0101
    cyc("indep_pre", 1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'hF);
    cyc("indep", 1'b0, 1'b1, 4'b1100, 4'b1010, 4'hF, 4'b0101);

`ifdef MS_JK_CLKEN_EN
    cyc("ce_off", 1'b0, 1'b0, 4'hF, 4'h0, 4'h5, 4'h5);
    cyc("ce_on",  1'b0, 1'b1, 4'hF, 4'h0, 4'h5, 4'hF);
    cyc("ce_a",   1'b0, 1'b1, 4'hA, 4'h5, 4'hF, 4'hA);
    cyc("ce_tog_off", 1'b0, 1'b0, 4'hF, 4'hF, 4'hA, 4'hA);
    cyc("ce_rst", 1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
`else
    cyc("wide_set", 1'b0, 1'b1, 4'hF, 4'h0, 4'h5, 4'hF);
    cyc("wide_a",   1'b0, 1'b1, 4'hA, 4'h5, 4'hF, 4'hA);
    cyc("wide_rst", 1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
